// File: rtl/decode_stage_hs_if.sv
// Fetch->decode->execute handshake bundle: instruction word in, decoded control word out.
// The slave modport is the decoder's view and the master modport is the surrounding pipeline's view.
interface decode_stage_hs_if #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [3:0]        flag;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_op;
  logic [3:0]        out_bits;
  logic [REG_W-1:0]  out_base;
  logic [REG_W-1:0]  out_data_reg;
  logic [11:0]       out_imm_mem;
  logic [ADDR_W-1:0] out_imm_br;
  logic              out_jmp_en;
  logic              out_flag_en;
  logic              out_write_data;
  logic              out_mem_rd;
  logic              out_mem_wr;
  logic              out_cond_fail;

  modport master (
    output in_valid, instr, flag, out_ready,
    input  in_ready, out_valid, out_op, out_bits, out_base, out_data_reg,
           out_imm_mem, out_imm_br, out_jmp_en, out_flag_en, out_write_data,
           out_mem_rd, out_mem_wr, out_cond_fail
  );

  modport slave (
    input  in_valid, instr, flag, out_ready,
    output in_ready, out_valid, out_op, out_bits, out_base, out_data_reg,
           out_imm_mem, out_imm_br, out_jmp_en, out_flag_en, out_write_data,
           out_mem_rd, out_mem_wr, out_cond_fail
  );
endinterface

// File: rtl/decode_stage_hs.sv
// Handshaked instruction decoder with an output register plus one skid entry for full throughput.
// Define DECODE_COND_EN to gate enables on instr[31:28] against {N,Z,C,V}; otherwise every word executes.
module decode_stage_hs #(
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  decode_stage_hs_if.slave   bus,
  output logic [COUNT_W-1:0] dec_count
);

  typedef struct packed {
    logic [1:0]        op;
    logic [3:0]        bits;
    logic [REG_W-1:0]  base;
    logic [REG_W-1:0]  data_reg;
    logic [11:0]       imm_mem;
    logic [ADDR_W-1:0] imm_br;
    logic              jmp_en;
    logic              flag_en;
    logic              write_data;
    logic              mem_rd;
    logic              mem_wr;
    logic              cond_fail;
  } dec_t;

  dec_t dec, out_q, skid_q;
  logic out_valid, skid_valid;
  logic accept, drain, pass;

`ifdef DECODE_COND_EN
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    return z;
      4'h1:    return ~z;
      4'h2:    return cy;
      4'h3:    return ~cy;
      4'h4:    return n;
      4'h5:    return ~n;
      4'h6:    return v;
      4'h7:    return ~v;
      4'h8:    return cy & ~z;
      4'h9:    return ~cy | z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return ~z & (n == v);
      4'hD:    return z | (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign pass = cond_pass(bus.instr[31:28], bus.flag);
`else
  logic unused_cond;
  assign unused_cond = ^{bus.instr[31:28], bus.flag};
  assign pass        = 1'b1;
`endif

  // Decode always works on the word presented this cycle; fields stay decoded even when the condition fails.
  always_comb begin
    dec    = '0;
    dec.op = bus.instr[27:26];
    if (dec.op != 2'd3) begin
      dec.bits      = bus.instr[24:21];
      dec.cond_fail = ~pass;
    end
    case (dec.op)
      2'd0: begin
        dec.base       = bus.instr[16 +: REG_W];
        dec.data_reg   = bus.instr[12 +: REG_W];
        dec.flag_en    = bus.instr[20] & pass;
        dec.write_data = (bus.instr[24:21] != 4'd10) & pass;
      end
      2'd1: begin
        dec.base     = bus.instr[16 +: REG_W];
        dec.data_reg = bus.instr[12 +: REG_W];
        dec.imm_mem  = bus.instr[25] ? bus.instr[11:0] : 12'd0;
        dec.mem_rd   = bus.instr[20] & pass;
        dec.mem_wr   = ~bus.instr[20] & pass;
      end
      2'd2: begin
        dec.imm_br = ADDR_W'($signed({bus.instr[23:0], 2'b00}));
        dec.jmp_en = pass;
      end
      default: ;
    endcase
  end

  assign bus.in_ready = ~skid_valid & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign drain        = ~out_valid | bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      dec_count  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (out_valid & bus.out_ready)
        dec_count <= dec_count + COUNT_W'(1);
      if (drain) begin
        // Skid holds the older word, so it always leaves first.
        if (skid_valid | accept)
          out_q <= skid_valid ? skid_q : dec;
        out_valid  <= skid_valid | accept;
        skid_valid <= skid_valid & accept;
        if (skid_valid & accept)
          skid_q <= dec;
      end else if (accept) begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
      end
    end
  end

  assign bus.out_valid      = out_valid;
  assign bus.out_op         = out_q.op;
  assign bus.out_bits       = out_q.bits;
  assign bus.out_base       = out_q.base;
  assign bus.out_data_reg   = out_q.data_reg;
  assign bus.out_imm_mem    = out_q.imm_mem;
  assign bus.out_imm_br     = out_q.imm_br;
  assign bus.out_jmp_en     = out_q.jmp_en;
  assign bus.out_flag_en    = out_q.flag_en;
  assign bus.out_write_data = out_q.write_data;
  assign bus.out_mem_rd     = out_q.mem_rd;
  assign bus.out_mem_wr     = out_q.mem_wr;
  assign bus.out_cond_fail  = out_q.cond_fail;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: decode fields, backpressure/skid, flush, reset and counter wrap.
module tb_decode_stage_hs;
  localparam int ADDR_W  = 32;
  localparam int REG_W   = 4;
  localparam int COUNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [COUNT_W-1:0] dec_count;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage_hs_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  decode_stage_hs #(.ADDR_W(ADDR_W), .REG_W(REG_W), .COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .dec_count (dec_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [3:0] f, input logic rdy);
    bus.in_valid  = v;
    bus.instr     = w;
    bus.flag      = f;
    bus.out_ready = rdy;
  endtask

  localparam logic [31:0] W1 = 32'hE0811002; // Rd=1
  localparam logic [31:0] W2 = 32'hE0822003; // Rd=2
  localparam logic [31:0] W3 = 32'hE0833004; // Rd=3
  localparam logic [31:0] W4 = 32'hE0844005; // Rd=4

  initial begin
    drive(1'b0, 32'h0, 4'h0, 1'b1);
    tick(); tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_count", dec_count, 0);
    chk("rst_op", bus.out_op, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // back-to-back stream with out_ready=1
    drive(1'b1, 32'hE0912003, 4'h0, 1'b1);
    tick();
    chk("adds_valid", bus.out_valid, 1);
    chk("adds_op", bus.out_op, 0);
    chk("adds_bits", bus.out_bits, 4);
    chk("adds_base", bus.out_base, 1);
    chk("adds_rd", bus.out_data_reg, 2);
    chk("adds_flag_en", bus.out_flag_en, 1);
    chk("adds_write", bus.out_write_data, 1);
    chk("adds_imm_mem", bus.out_imm_mem, 0);
    chk("adds_cnt", dec_count, 0);

    drive(1'b1, 32'hE5912004, 4'h0, 1'b1);
    tick();
    chk("ldr_op", bus.out_op, 1);
    chk("ldr_rd", bus.out_mem_rd, 1);
    chk("ldr_wr", bus.out_mem_wr, 0);
    chk("ldr_write", bus.out_write_data, 0);
    chk("ldr_cnt", dec_count, 1);

    drive(1'b1, 32'hE5812004, 4'h0, 1'b1);
    tick();
    chk("str_wr", bus.out_mem_wr, 1);
    chk("str_rd", bus.out_mem_rd, 0);
    chk("str_cnt", dec_count, 2);

    drive(1'b1, 32'hE7912004, 4'h0, 1'b1);
    tick();
    chk("ldri_imm", bus.out_imm_mem, 12'h004);
    chk("ldri_base", bus.out_base, 1);
    chk("ldri_cnt", dec_count, 3);

    drive(1'b1, 32'hE1510002, 4'h0, 1'b1);
    tick();
    chk("cmp_bits", bus.out_bits, 10);
    chk("cmp_write", bus.out_write_data, 0);
    chk("cmp_flag_en", bus.out_flag_en, 1);
    chk("cmp_cnt", dec_count, 4);

    drive(1'b1, 32'hEAFFFFFE, 4'h0, 1'b1);
    tick();
    chk("b_op", bus.out_op, 2);
    chk("b_jmp", bus.out_jmp_en, 1);
    chk("b_imm_br", bus.out_imm_br, 32'hFFFFFFF8);
    chk("b_base", bus.out_base, 0);
    chk("b_cnt", dec_count, 5);

    drive(1'b1, 32'h0A000001, 4'b0000, 1'b1);
    tick();
    chk("beq_z0_imm_br", bus.out_imm_br, 32'h4);
`ifdef DECODE_COND_EN
    chk("beq_z0_fail", bus.out_cond_fail, 1);
    chk("beq_z0_jmp", bus.out_jmp_en, 0);
`else
    chk("beq_z0_fail", bus.out_cond_fail, 0);
    chk("beq_z0_jmp", bus.out_jmp_en, 1);
`endif

    drive(1'b1, 32'h0A000001, 4'b0100, 1'b1);
    tick();
    chk("beq_z1_fail", bus.out_cond_fail, 0);
    chk("beq_z1_jmp", bus.out_jmp_en, 1);

    drive(1'b1, 32'hEC123456, 4'h0, 1'b1);
    tick();
    chk("op3_valid", bus.out_valid, 1);
    chk("op3_op", bus.out_op, 3);
    chk("op3_bits", bus.out_bits, 0);
    chk("op3_base", bus.out_base, 0);
    chk("op3_imm_br", bus.out_imm_br, 0);
    chk("op3_en", {bus.out_jmp_en, bus.out_flag_en, bus.out_write_data,
                   bus.out_mem_rd, bus.out_mem_wr, bus.out_cond_fail}, 0);
    chk("op3_cnt", dec_count, 8);

    drive(1'b0, 32'h0, 4'h0, 1'b1);
    tick();
    chk("idle_valid", bus.out_valid, 0);
    chk("idle_cnt", dec_count, 9);

    // backpressure: three stalled cycles fill out reg and skid
    drive(1'b1, W1, 4'h0, 1'b0);
    tick();
    chk("bp1_rd", bus.out_data_reg, 1);
    chk("bp1_ready", bus.in_ready, 1);
    drive(1'b1, W2, 4'h0, 1'b0);
    tick();
    chk("bp2_ready", bus.in_ready, 0);
    chk("bp2_rd", bus.out_data_reg, 1);
    drive(1'b1, W3, 4'h0, 1'b0);
    tick();
    chk("bp3_ready", bus.in_ready, 0);
    chk("bp3_rd", bus.out_data_reg, 1);
    chk("bp3_valid", bus.out_valid, 1);
    chk("bp3_cnt", dec_count, 9);
    drive(1'b1, W3, 4'h0, 1'b1);
    tick();
    chk("rel1_rd", bus.out_data_reg, 2);
    chk("rel1_cnt", dec_count, 10);
    chk("rel1_ready", bus.in_ready, 1);
    tick();
    chk("rel2_rd", bus.out_data_reg, 3);
    chk("rel2_cnt", dec_count, 11);
    drive(1'b0, W3, 4'h0, 1'b1);
    tick();
    chk("rel3_valid", bus.out_valid, 0);
    chk("rel3_cnt", dec_count, 12);

    // flush with both entries full and a word offered
    drive(1'b1, W1, 4'h0, 1'b0);
    tick();
    drive(1'b1, W2, 4'h0, 1'b0);
    tick();
    chk("fl_full_ready", bus.in_ready, 0);
    flush = 1'b1;
    drive(1'b1, W4, 4'h0, 1'b1);
    tick();
    flush = 1'b0;
    chk("fl_valid", bus.out_valid, 0);
    chk("fl_ready", bus.in_ready, 1);
    chk("fl_cnt", dec_count, 12);
    drive(1'b1, W3, 4'h0, 1'b1);
    tick();
    chk("fl_next_rd", bus.out_data_reg, 3);
    drive(1'b0, W3, 4'h0, 1'b1);
    tick();
    chk("fl_after_valid", bus.out_valid, 0);
    chk("fl_after_cnt", dec_count, 13);

    // reset mid-stream with skid full
    drive(1'b1, W1, 4'h0, 1'b0);
    tick();
    drive(1'b1, W2, 4'h0, 1'b0);
    tick();
    chk("mr_full_ready", bus.in_ready, 0);
    rst = 1'b1;
    tick();
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_ready_in_rst", bus.in_ready, 0);
    chk("mr_cnt", dec_count, 0);
    rst = 1'b0;
    drive(1'b0, W1, 4'h0, 1'b1);
    #1;
    chk("mr_ready", bus.in_ready, 1);
    tick();
    chk("mr_idle_valid", bus.out_valid, 0);

    // counter wrap: 15 handshakes reach max, the 16th wraps to 0
    drive(1'b1, W1, 4'h0, 1'b1);
    for (int i = 0; i < 16; i++) tick();
    chk("wrap_max", dec_count, 15);
    tick();
    chk("wrap_zero", dec_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
